canon_sequencer: RTL

Tempo-driven note sequencer that feeds the PWM tone stage and the display. It divides the system clock into crotchet beats and steps a 128-entry melody ROM once per beat. Per beat it presents the current note's half-period code (`low_count`) and the beat index (`crotchet`), and gates each note with a short silent articulation gap. Both downstream consumers read its outputs directly; no handshake back.

---
 rtl/canon_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/canon_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : canon_sequencer
// Brief    : Tempo-driven 128-beat melody sequencer with per-beat articulation
//            gap, feeding the PWM tone stage and the display.
// Revision : 1.0 - initial release
// ============================================================================
module canon_sequencer #(
    parameter int TICKS_PER_CROTCHET = 12_587_500,
    parameter int GAP_CYCLES         = 251_750,
    parameter int CNT_W              = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] fast_start,
    input  logic       pause,
    output logic [9:0] low_count,
    output logic [6:0] crotchet,
    output logic       gate,
    output logic       note_start
);

    localparam logic [1:0] c_ST_INIT = 2'd0;
    localparam logic [1:0] c_ST_NOTE = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    localparam logic [CNT_W-1:0] c_NOTE_LAST = CNT_W'(TICKS_PER_CROTCHET - GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_BEAT_LAST = CNT_W'(TICKS_PER_CROTCHET - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam bit               c_HAS_GAP   = (GAP_CYCLES != 0);

    // Melody: note code per beat, 0 = rest.
    localparam logic [4:0] c_MELODY [0:127] = '{
        5'd18, 5'd13, 5'd15, 5'd10, 5'd11, 5'd6,  5'd6,  5'd0,
        5'd18, 5'd17, 5'd15, 5'd13, 5'd11, 5'd10, 5'd11, 5'd13,
        5'd15, 5'd13, 5'd11, 5'd10, 5'd8,  5'd11, 5'd10, 5'd8,
        5'd6,  5'd8,  5'd10, 5'd11, 5'd13, 5'd11, 5'd10, 5'd0,
        5'd22, 5'd20, 5'd18, 5'd17, 5'd15, 5'd13, 5'd15, 5'd17,
        5'd18, 5'd17, 5'd15, 5'd13, 5'd11, 5'd10, 5'd11, 5'd13,
        5'd15, 5'd15, 5'd18, 5'd18, 5'd20, 5'd20, 5'd22, 5'd0,
        5'd25, 5'd22, 5'd23, 5'd20, 5'd22, 5'd18, 5'd22, 5'd23,
        5'd25, 5'd25, 5'd22, 5'd22, 5'd23, 5'd23, 5'd20, 5'd20,
        5'd22, 5'd22, 5'd18, 5'd18, 5'd22, 5'd22, 5'd23, 5'd0,
        5'd27, 5'd25, 5'd23, 5'd22, 5'd20, 5'd18, 5'd20, 5'd22,
        5'd23, 5'd22, 5'd20, 5'd18, 5'd17, 5'd15, 5'd17, 5'd18,
        5'd30, 5'd29, 5'd27, 5'd25, 5'd23, 5'd22, 5'd23, 5'd25,
        5'd27, 5'd25, 5'd23, 5'd22, 5'd20, 5'd18, 5'd20, 5'd22,
        5'd23, 5'd0,  5'd20, 5'd0,  5'd22, 5'd0,  5'd18, 5'd0,
        5'd18, 5'd17, 5'd15, 5'd13, 5'd11, 5'd10, 5'd6,  5'd0
    };

    // Half-period codes, rising pitch with note code; code 0 is silence.
    localparam logic [9:0] c_NOTE_HP [0:31] = '{
        10'd0,   10'd956, 10'd902, 10'd851, 10'd804, 10'd758, 10'd716, 10'd676,
        10'd638, 10'd602, 10'd568, 10'd536, 10'd506, 10'd478, 10'd451, 10'd426,
        10'd402, 10'd379, 10'd358, 10'd338, 10'd319, 10'd301, 10'd284, 10'd268,
        10'd253, 10'd239, 10'd225, 10'd213, 10'd201, 10'd190, 10'd179, 10'd169
    };

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_crotchet;
    logic [9:0]       r_low_count;
    logic             r_gate;
    logic             r_note_start;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [6:0]       w_crot_nxt;
    logic             w_beat_start;
    logic             w_pause_eff;
    logic [9:0]       w_low_count_nxt;
    logic             w_gate_nxt;
    logic             w_note_start_nxt;

    assign w_pause_eff = pause && (r_state != c_ST_INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_INIT;
            r_cnt        <= '0;
            r_crotchet   <= '0;
            r_low_count  <= '0;
            r_gate       <= 1'b0;
            r_note_start <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_crotchet   <= w_crot_nxt;
            r_low_count  <= w_low_count_nxt;
            r_gate       <= w_gate_nxt;
            r_note_start <= w_note_start_nxt;
        end
    end

    // A beat boundary is folded into the last counter cycle of NOTE or GAP.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_crot_nxt   = r_crotchet;
        w_beat_start = 1'b0;
        case (r_state)
            c_ST_INIT: begin
                w_state_nxt  = c_ST_NOTE;
                w_cnt_nxt    = '0;
                w_crot_nxt   = {fast_start, 5'b0};
                w_beat_start = 1'b1;
            end
            c_ST_NOTE: begin
                if (!pause) begin
                    if ((r_cnt == c_NOTE_LAST) && !c_HAS_GAP) begin
                        w_cnt_nxt    = '0;
                        w_crot_nxt   = r_crotchet + 7'd1;
                        w_beat_start = 1'b1;
                    end else begin
                        if (r_cnt == c_NOTE_LAST) begin
                            w_state_nxt = c_ST_GAP;
                        end
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            c_ST_GAP: begin
                if (!pause) begin
                    if (r_cnt == c_BEAT_LAST) begin
                        w_state_nxt  = c_ST_NOTE;
                        w_cnt_nxt    = '0;
                        w_crot_nxt   = r_crotchet + 7'd1;
                        w_beat_start = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they change
    // on the same edge as the state and beat index.
    always_comb begin
        w_low_count_nxt  = c_NOTE_HP[c_MELODY[w_crot_nxt]];
        w_note_start_nxt = w_beat_start;
        w_gate_nxt       = (w_state_nxt == c_ST_NOTE) && !w_pause_eff
                           && (w_low_count_nxt != '0);
    end

    assign low_count  = r_low_count;
    assign crotchet   = r_crotchet;
    assign gate       = r_gate;
    assign note_start = r_note_start;

endmodule
`default_nettype wire
